data_to_axi_stream_wide: RTL and testbench
==========================================

// Module: data_to_axi_stream_wide
// PURPOSE
//  Parametrised successor of the packet-to-AXI-Stream bridge: buffers DATA_WIDTH trace packets
//  in an internal FIFO and serialises each into DATA_WIDTH/AXIS_WIDTH beats on an AXI4-Stream
//  master at up to one beat per cycle (no inter-packet bubble). Frames close with tlast every
//  tlast_interval packets or on force_tlast. Overflow is dropped and counted, never stalls the source.
// PARAMETERS
//  DATA_WIDTH  1024  input packet width; integer multiple of AXIS_WIDTH
//  AXIS_WIDTH  256   output beat width (tdata)
//  FIFO_DEPTH  32    packets buffered; power of two, >= 2
// PORTS
//  clk             in   1                 single clock, all logic rising-edge
//  rst             in   1                 synchronous, active-high reset
//  write_enable    in   1                 data_pkt valid this cycle
//  data_pkt        in   DATA_WIDTH        packet to enqueue
//  tlast_interval  in   32                packets per frame; 0 treated as 1
//  force_tlast     in   1                 pulse: end frame on packet in output stage, else next one
//  M_AXIS_tvalid   out  1                 beat valid
//  M_AXIS_tready   in   1                 sink ready
//  M_AXIS_tdata    out  AXIS_WIDTH        beat data
//  M_AXIS_tlast    out  1                 final beat of frame
//  fifo_full       out  1                 FIFO holds FIFO_DEPTH packets
//  fifo_level      out  $clog2(DEPTH)+1   packets in FIFO (excludes output stage)
//  dropped_count   out  32                packets lost to overflow, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO emptied; beat index, packet counter, force flag cleared; partially
//    sent packet discarded (no tlast emitted). Reset mid-transfer obeys the same rule.
//  - Write: enqueue iff write_enable && !fifo_full (registered flag). Write while full is dropped even
//    if a pop occurs that cycle; dropped_count += 1, holds at 32'hFFFFFFFF.
//  - Output stage: holding reg + beat_idx (0..BEATS-1), BEATS=DATA_WIDTH/AXIS_WIDTH. Pop head into it
//    when stage empty, or when last beat accepted this cycle (back-to-back, no idle cycle).
//  - Latency: packet written at edge t -> tvalid=1 after edge t+1 if stage was empty.
//  - tdata = slice beat_idx of holding reg, LS slice first. Beat accepted on tvalid && tready;
//    tdata/tlast/tvalid stable while tvalid && !tready. beat_idx wraps BEATS-1 -> 0.
//  - States: EMPTY (tvalid=0) / SEND (tvalid=1). EMPTY->SEND on pop; SEND->EMPTY on last-beat
//    accept with FIFO empty; otherwise stays SEND.
//  - pkt_cnt (32b) counts packets accepted in current frame. tlast=1 only on beat BEATS-1 and when
//    pkt_cnt >= max(tlast_interval,1)-1 or force_pend. On accept of tlast beat: pkt_cnt=0, force_pend=0.
//    '>=' closes frame at once if tlast_interval is lowered mid-frame.
//  - force_pend set by force_tlast; force_tlast coincident with accept of tlast=1 beat is absorbed.
//  - BEATS=1: every beat is last beat; behaviour reduces to one packet per beat.
//  - Simultaneous push+pop: level unchanged; push when empty + stage empty still costs 1 cycle.
// TESTING
//  1 DATA=1024,AXIS=256,interval=1, 1 pkt 0x..03_02_01_00 words, tready=1 -> 4 beats slices 0..3 on
//    consecutive cycles, tlast only on 4th, tvalid first 2 edges after write.
//  2 interval=3, 7 pkts back-to-back, tready=1 -> 28 contiguous beats, tlast on beats 12,24; none on 28.
//  3 tready toggled 1010.. / held 0 for 20 cycles -> tdata,tlast stable while stalled; no beat lost/duped.
//  4 tready=0, 40 writes DEPTH=32 -> 32 queued + 1 in stage, fifo_full=1, dropped_count=7; drain yields
//    first 33 pkts in order.
//  5 interval=100, 5 pkts, force_tlast during pkt 2 beat 1 -> tlast on pkt 2 last beat; pkt_cnt restarts.
//  6 rst asserted mid-packet (beat 2 of 4) -> next cycle tvalid=0, level=0, dropped_count=0; new pkt
//    after release starts at beat 0 with pkt_cnt=0.

Source files
------------

// File: rtl/data_to_axi_stream_wide_if.sv
`default_nettype none
// data_to_axi_stream_wide_if: AXI4-Stream beat bundle between the packet bridge and its sink.
interface data_to_axi_stream_wide_if #(
   parameter int AXIS_WIDTH = 256
);
   logic                  tvalid;
   logic                  tready;
   logic [AXIS_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/data_to_axi_stream_wide.sv
`default_nettype none
// data_to_axi_stream_wide: FIFO-buffered wide trace packets serialised into AXI4-Stream beats,
// framed by tlast every tlast_interval packets or on force_tlast; overflow is dropped and counted.
module data_to_axi_stream_wide #(
   parameter int DATA_WIDTH = 1024,
   parameter int AXIS_WIDTH = 256,
   parameter int FIFO_DEPTH = 32
) (
   input  wire                          clk,
   input  wire                          rst,
   input  wire                          write_enable,
   input  wire [DATA_WIDTH-1:0]         data_pkt,
   input  wire [31:0]                   tlast_interval,
   input  wire                          force_tlast,
   data_to_axi_stream_wide_if.master    M_AXIS,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [31:0]                  dropped_count
);
   localparam int BEATS = DATA_WIDTH / AXIS_WIDTH;
   localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam logic [BIW-1:0] LAST_BEAT  = BIW'(BEATS - 1);
   localparam logic [LW-1:0]  ALMOST_LVL = LW'(FIFO_DEPTH - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_SEND  = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]                    wr_ptr;
   logic [AW-1:0]                    rd_ptr;
   logic [LW-1:0]                    level;
   logic                             full;
   logic [31:0]                      drop_cnt;

   state_t                           state;
   logic [BEATS-1:0][AXIS_WIDTH-1:0] hold;
   logic [BIW-1:0]                   beat_idx;
   logic [31:0]                      pkt_cnt;
   logic                             force_pend;

   logic                             push;
   logic                             pop;
   logic                             accept;
   logic                             last_accept;
   logic                             tlast_now;
   logic                             frame_end;
   logic [31:0]                      interval_m1;

   // A write while full is lost even if the same cycle frees a slot.
   assign push        = write_enable && !full;
   assign accept      = (state == ST_SEND) && M_AXIS.tready;
   assign last_accept = accept && (beat_idx == LAST_BEAT);
   assign pop         = (level != '0) && ((state == ST_EMPTY) || last_accept);

   assign interval_m1 = (tlast_interval == 32'd0) ? 32'd0 : (tlast_interval - 32'd1);
   assign tlast_now   = (state == ST_SEND) && (beat_idx == LAST_BEAT) &&
                        ((pkt_cnt >= interval_m1) || force_pend);
   assign frame_end   = accept && tlast_now;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_pkt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10: begin
               level <= level + LW'(1);
               full  <= (level == ALMOST_LVL);
            end
            2'b01: begin
               level <= level - LW'(1);
               full  <= 1'b0;
            end
            default: begin
               level <= level;
               full  <= full;
            end
         endcase
         if (write_enable && full && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
         end
      end
   end

   // Output stage: refilled on the same edge its last beat leaves, so packets stream without bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         hold       <= '0;
         beat_idx   <= '0;
         pkt_cnt    <= '0;
         force_pend <= 1'b0;
      end else begin
         if (pop) begin
            hold  <= mem[rd_ptr];
            state <= ST_SEND;
         end else if (last_accept) begin
            state <= ST_EMPTY;
         end

         if (accept) begin
            beat_idx <= (beat_idx == LAST_BEAT) ? '0 : (beat_idx + BIW'(1));
         end

         // Closing a frame absorbs a force_tlast arriving on the same edge.
         if (frame_end) begin
            pkt_cnt    <= '0;
            force_pend <= 1'b0;
         end else begin
            if (last_accept && (pkt_cnt != 32'hFFFF_FFFF)) begin
               pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (force_tlast) begin
               force_pend <= 1'b1;
            end
         end
      end
   end

   assign M_AXIS.tvalid = (state == ST_SEND);
   assign M_AXIS.tdata  = hold[beat_idx];
   assign M_AXIS.tlast  = tlast_now;

   assign fifo_full     = full;
   assign fifo_level    = level;
   assign dropped_count = drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_data_to_axi_stream_wide.sv
`default_nettype none
// tb_data_to_axi_stream_wide: table vectors, directed corner sequences and randomized traffic
// checked against a packet-level reference model of the bridge.
module tb_data_to_axi_stream_wide;
   localparam int DATA_WIDTH = 1024;
   localparam int AXIS_WIDTH = 256;
   localparam int FIFO_DEPTH = 32;
   localparam int BEATS      = DATA_WIDTH / AXIS_WIDTH;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] data_pkt;
   logic [31:0]           tlast_interval;
   logic                  force_tlast;
   logic                  fifo_full;
   logic [LW-1:0]         fifo_level;
   logic [31:0]           dropped_count;

   always #5 clk = ~clk;

   data_to_axi_stream_wide_if #(.AXIS_WIDTH(AXIS_WIDTH)) axis ();

   data_to_axi_stream_wide #(
      .DATA_WIDTH(DATA_WIDTH), .AXIS_WIDTH(AXIS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .write_enable(write_enable), .data_pkt(data_pkt),
      .tlast_interval(tlast_interval), .force_tlast(force_tlast), .M_AXIS(axis),
      .fifo_full(fifo_full), .fifo_level(fifo_level), .dropped_count(dropped_count)
   );

   typedef struct {
      logic [AXIS_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   typedef struct {
      int interval;
      int npkts;
      int exp_beats;
      int exp_lasts;
   } vec_t;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q[$];
   int    frame_n;
   int    interval_eff;
   bit    mon_en = 1'b0;
   int    mon_beats, mon_lasts, first_cyc, last_cyc;
   int    cyc = 0;
   logic  prev_stall;
   logic [AXIS_WIDTH-1:0] prev_data;
   logic  prev_last;

   task automatic check(input string name, input logic [AXIS_WIDTH-1:0] act,
                        input logic [AXIS_WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_WIDTH-1:0] rand_pkt();
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Every interval_eff-th packet since the last frame close ends a frame.
   function automatic logic frame_last();
      frame_n++;
      if (frame_n >= interval_eff) begin
         frame_n = 0;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_pkt(input logic [DATA_WIDTH-1:0] p, input logic last);
      beat_t b;
      for (int i = 0; i < BEATS; i++) begin
         b.data = p[i*AXIS_WIDTH +: AXIS_WIDTH];
         b.last = last && (i == BEATS - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic write_pkt(input logic [DATA_WIDTH-1:0] p);
      write_enable = 1'b1;
      data_pkt     = p;
      @(posedge clk); #1;
      write_enable = 1'b0;
   endtask

   task automatic send_pkt(input logic [DATA_WIDTH-1:0] p);
      model_pkt(p, frame_last());
      write_pkt(p);
   endtask

   task automatic mon_clear();
      exp_q.delete();
      mon_beats  = 0;
      mon_lasts  = 0;
      first_cyc  = 0;
      last_cyc   = 0;
      prev_stall = 1'b0;
      frame_n    = 0;
   endtask

   task automatic do_reset();
      mon_en       = 1'b0;
      rst          = 1'b1;
      write_enable = 1'b0;
      force_tlast  = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mon_clear();
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("drain_remaining", exp_q.size(), 0);
   endtask

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            check("stall_tvalid", axis.tvalid, 1'b1);
            check("stall_tdata", axis.tdata, prev_data);
            check("stall_tlast", axis.tlast, prev_last);
         end
         if (axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h expected no beat", axis.tdata);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", axis.tdata, e.data);
               check("beat_last", axis.tlast, e.last);
            end
            if (mon_beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            mon_beats++;
            if (axis.tlast) mon_lasts++;
         end
         prev_stall = axis.tvalid && !axis.tready;
         prev_data  = axis.tdata;
         prev_last  = axis.tlast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[5];
      logic [DATA_WIDTH-1:0] p1, pa, pb;
      int wr_cnt;

      vecs[0] = '{interval: 0, npkts: 3, exp_beats: 12, exp_lasts: 3};
      vecs[1] = '{interval: 1, npkts: 2, exp_beats: 8,  exp_lasts: 2};
      vecs[2] = '{interval: 3, npkts: 7, exp_beats: 28, exp_lasts: 2};
      vecs[3] = '{interval: 2, npkts: 5, exp_beats: 20, exp_lasts: 2};
      vecs[4] = '{interval: 4, npkts: 8, exp_beats: 32, exp_lasts: 2};

      rst = 1'b1; write_enable = 1'b0; force_tlast = 1'b0; data_pkt = '0;
      tlast_interval = 32'd1; axis.tready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_tvalid", axis.tvalid, 1'b0);
      check("rst_tlast", axis.tlast, 1'b0);
      check("rst_tdata", axis.tdata, '0);
      check("rst_full", fifo_full, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_dropped", dropped_count, 0);

      // Single packet: latency and beat order.
      do_reset();
      tlast_interval = 32'd1; axis.tready = 1'b1;
      for (int i = 0; i < DATA_WIDTH / 8; i++) p1[i*8 +: 8] = 8'(i);
      write_pkt(p1);
      check("lat_after_write_edge", axis.tvalid, 1'b0);
      @(posedge clk); #1;
      for (int b = 0; b < BEATS; b++) begin
         check("single_tvalid", axis.tvalid, 1'b1);
         check("single_tdata", axis.tdata, p1[b*AXIS_WIDTH +: AXIS_WIDTH]);
         check("single_tlast", axis.tlast, (b == BEATS - 1));
         @(posedge clk); #1;
      end
      check("single_idle", axis.tvalid, 1'b0);

      // Table: frame spacing and back-to-back streaming.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         tlast_interval = vecs[v].interval;
         interval_eff   = (vecs[v].interval == 0) ? 1 : vecs[v].interval;
         axis.tready    = 1'b1;
         mon_en         = 1'b1;
         for (int p = 0; p < vecs[v].npkts; p++) send_pkt(rand_pkt());
         drain(300);
         check("vec_beats", mon_beats, vecs[v].exp_beats);
         check("vec_lasts", mon_lasts, vecs[v].exp_lasts);
         check("vec_span", last_cyc - first_cyc + 1, vecs[v].exp_beats);
      end

      // force_tlast during packet 2 beat 1 with interval 3: frames close on packets 2 and 5.
      do_reset();
      tlast_interval = 32'd3; axis.tready = 1'b1; mon_en = 1'b1;
      for (int p = 0; p < 6; p++) begin
         pa = rand_pkt();
         model_pkt(pa, (p == 1) || (p == 4));
         write_pkt(pa);
      end
      @(posedge clk); #1;
      force_tlast = 1'b1;
      @(posedge clk); #1;
      force_tlast = 1'b0;
      drain(300);
      check("force_beats", mon_beats, 6 * BEATS);
      check("force_lasts", mon_lasts, 2);

      // Overflow with the sink stalled.
      do_reset();
      tlast_interval = 32'd1; interval_eff = 1; axis.tready = 1'b0; mon_en = 1'b1;
      for (int p = 0; p < 40; p++) begin
         pa = rand_pkt();
         if (p < FIFO_DEPTH + 1) model_pkt(pa, frame_last());
         write_pkt(pa);
      end
      check("ovf_full", fifo_full, 1'b1);
      check("ovf_level", fifo_level, FIFO_DEPTH);
      check("ovf_dropped", dropped_count, 7);
      check("ovf_tvalid", axis.tvalid, 1'b1);
      axis.tready = 1'b1;
      drain(400);
      check("ovf_beats", mon_beats, (FIFO_DEPTH + 1) * BEATS);
      check("ovf_level_drained", fifo_level, 0);
      check("ovf_full_drained", fifo_full, 1'b0);
      check("ovf_dropped_hold", dropped_count, 7);

      // Reset in the middle of a packet, with drops and a partial frame outstanding.
      mon_en = 1'b0;
      tlast_interval = 32'd2; axis.tready = 1'b1;
      pa = rand_pkt();
      pb = rand_pkt();
      write_pkt(pa);
      write_pkt(pb);
      repeat (6) @(posedge clk);
      #1;
      check("midrst_tvalid_pre", axis.tvalid, 1'b1);
      check("midrst_beat2_pre", axis.tdata, pb[2*AXIS_WIDTH +: AXIS_WIDTH]);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_tvalid", axis.tvalid, 1'b0);
      check("midrst_tlast", axis.tlast, 1'b0);
      check("midrst_level", fifo_level, 0);
      check("midrst_dropped", dropped_count, 0);
      rst = 1'b0;
      mon_clear();
      interval_eff = 2; mon_en = 1'b1;
      send_pkt(rand_pkt());
      send_pkt(rand_pkt());
      drain(100);
      check("midrst_beats", mon_beats, 2 * BEATS);
      check("midrst_lasts", mon_lasts, 1);

      // Randomized traffic with random, alternating and stalled sink readiness.
      do_reset();
      interval_eff   = $urandom_range(1, 4);
      tlast_interval = interval_eff;
      mon_en = 1'b1;
      wr_cnt = 0;
      for (int c = 0; c < 1500; c++) begin
         if (c >= 400 && c < 440)      axis.tready = c[0];
         else if (c >= 440 && c < 460) axis.tready = 1'b0;
         else                          axis.tready = 1'($urandom_range(0, 1));
         if (($urandom_range(0, 2) == 0) && (wr_cnt - mon_beats / BEATS < 30)) begin
            pa = rand_pkt();
            model_pkt(pa, frame_last());
            write_enable = 1'b1;
            data_pkt     = pa;
            wr_cnt++;
         end else begin
            write_enable = 1'b0;
         end
         @(posedge clk); #1;
      end
      write_enable = 1'b0;
      axis.tready  = 1'b1;
      drain(2000);
      check("rand_beats", mon_beats, wr_cnt * BEATS);
      check("rand_dropped", dropped_count, 0);
      check("rand_level", fifo_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
